// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for logic_unit_arbiter.
// slave modport is the arbiter side; master is the requester/consumer side.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 2
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Shared NOT/AND/OR/XOR unit arbitrated among NREQ requesters, single-entry output register.
// Define LOGIC_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (lowest index wins).
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 2
) (
    input logic                 clk,
    input logic                 reset,
    logic_unit_arbiter_if.slave bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             slot_free;
    logic             gnt_any;
    logic             grant;
    logic [IDW-1:0]   gnt_idx;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] alu_res;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] last_q, last_d;

    // Pick the valid requester closest after last_q in circular order.
    always_comb begin
        int unsigned last_u;
        int unsigned dist;
        int unsigned best;
        gnt_any = 1'b0;
        gnt_idx = '0;
        last_u  = 32'(last_q);
        best    = NREQ + 1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            dist = (i > last_u) ? (i - last_u) : (i + NREQ - last_u);
            if (bus.req_valid[i] && (dist < best)) begin
                best    = dist;
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !gnt_any) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end
`endif

    assign slot_free = (state_q == StEmpty) || bus.rsp_ready;
    // Reset suppresses every handshake, including a drain-and-refill.
    assign grant     = gnt_any && slot_free && !reset;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = grant && (gnt_idx == IDW'(i));
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_sel = bus.req_op[2*i +: 2];
                a_sel  = bus.req_a[WIDTH*i +: WIDTH];
                b_sel  = bus.req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        unique case (op_sel)
            2'b00:   alu_res = ~a_sel;
            2'b01:   alu_res = a_sel & b_sel;
            2'b10:   alu_res = a_sel | b_sel;
            default: alu_res = a_sel ^ b_sel;
        endcase
    end

    always_comb begin
        result_d = result_q;
        id_d     = id_q;
        if (grant) begin
            result_d = alu_res;
            id_d     = gnt_idx;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (grant) state_d = StFull;
            StFull:  if (bus.rsp_ready && !grant) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.rsp_valid  = (state_q == StFull);
        bus.rsp_id     = id_q;
        bus.rsp_result = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            id_q     <= '0;
        end else begin
            result_q <= result_d;
            id_q     <= id_d;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: NREQ=2 and NREQ=3 instances against a behavioural model.
// Expectations follow LOGIC_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_logic_unit_arbiter;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(W), .NREQ(2)) if2 ();
    logic_unit_arbiter_if #(.WIDTH(W), .NREQ(3)) if3 ();

    logic_unit_arbiter #(.WIDTH(W), .NREQ(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
    logic_unit_arbiter #(.WIDTH(W), .NREQ(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    // Model state per instance: 0 -> NREQ=2, 1 -> NREQ=3
    logic        m_full [2];
    logic [63:0] m_res  [2];
    int          m_id   [2];
    int          m_last [2];

    function automatic int pick(input int n, input logic [3:0] v, input int last);
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (last + k) % n;
            if (v[c]) return c;
        end
`else
        for (int i = 0; i < n; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [63:0] alu(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int n, input logic [3:0] v,
                              input logic [7:0] op, input logic [255:0] a,
                              input logic [255:0] b, input logic rr);
        int g;
        g = pick(n, v, m_last[k]);
        if (reset) begin
            m_full[k] = 1'b0;
            m_res[k]  = '0;
            m_id[k]   = 0;
            m_last[k] = n - 1;
        end else if ((!m_full[k] || rr) && g >= 0) begin
            m_res[k]  = alu(op[2*g +: 2], a[64*g +: 64], b[64*g +: 64]);
            m_id[k]   = g;
            m_full[k] = 1'b1;
            m_last[k] = g;
        end else if (m_full[k] && rr) begin
            m_full[k] = 1'b0;
        end
    endtask

    task automatic cmp_inst(input int k, input int n, input logic [3:0] v, input logic rr,
                            input logic [3:0] act_ready, input logic act_valid,
                            input logic [63:0] act_id, input logic [63:0] act_res);
        int         g;
        logic [3:0] exp_ready;
        g = pick(n, v, m_last[k]);
        exp_ready = (!reset && (!m_full[k] || rr) && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("req_ready_n%0d", n), {60'b0, act_ready}, {60'b0, exp_ready});
        chk($sformatf("rsp_valid_n%0d", n), {63'b0, act_valid}, {63'b0, m_full[k]});
        chk($sformatf("rsp_id_n%0d", n), act_id, 64'(m_id[k]));
        chk($sformatf("rsp_result_n%0d", n), act_res, m_res[k]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_res[k]  = '0;
            m_id[k]   = 0;
            m_last[k] = k + 1;
        end
    end

    always @(posedge clk) begin
        model_step(0, 2, {2'b0, if2.req_valid}, {4'b0, if2.req_op}, {128'b0, if2.req_a},
                   {128'b0, if2.req_b}, if2.rsp_ready);
        model_step(1, 3, {1'b0, if3.req_valid}, {2'b0, if3.req_op}, {64'b0, if3.req_a},
                   {64'b0, if3.req_b}, if3.rsp_ready);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, 2, {2'b0, if2.req_valid}, if2.rsp_ready, {2'b0, if2.req_ready},
                     if2.rsp_valid, {63'b0, if2.rsp_id}, if2.rsp_result);
            cmp_inst(1, 3, {1'b0, if3.req_valid}, if3.rsp_ready, {1'b0, if3.req_ready},
                     if3.rsp_valid, {62'b0, if3.rsp_id}, if3.rsp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] held;
    int          exp_id;

    initial begin
        if2.req_valid = '0; if2.req_op = '0; if2.req_a = '0; if2.req_b = '0;
        if2.rsp_ready = 1'b0;
        if3.req_valid = '0; if3.req_op = '0; if3.req_a = '0; if3.req_b = '0;
        if3.rsp_ready = 1'b0;

        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_rsp_valid", {63'b0, if2.rsp_valid}, 64'd0);
        chk("reset_rsp_result", if2.rsp_result, 64'd0);
        chk("reset_rsp_id_n3", {62'b0, if3.rsp_id}, 64'd0);

        // NOT of zero, then reset while FULL
        reset = 1'b0;
        if2.req_valid = 2'b01;
        if2.req_op    = 4'b0000;
        if2.req_a     = '0;
        tick();
        chk("not_valid", {63'b0, if2.rsp_valid}, 64'd1);
        chk("not_id", {63'b0, if2.rsp_id}, 64'd0);
        chk("not_result", if2.rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        if2.req_valid = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        chk("reset_full_valid", {63'b0, if2.rsp_valid}, 64'd0);
        reset = 1'b0;

        // Opcode sweep on requester 1
        if2.rsp_ready   = 1'b1;
        if2.req_valid   = 2'b10;
        if2.req_a[127:64] = 64'hF0F0_F0F0_F0F0_F0F0;
        if2.req_b[127:64] = 64'hFF00_FF00_FF00_FF00;
        if2.req_op[3:2] = 2'b01;
        tick();
        chk("and_result", if2.rsp_result, 64'hF000_F000_F000_F000);
        chk("and_id", {63'b0, if2.rsp_id}, 64'd1);
        if2.req_op[3:2] = 2'b10;
        tick();
        chk("or_result", if2.rsp_result, 64'hFFF0_FFF0_FFF0_FFF0);
        chk("or_id", {63'b0, if2.rsp_id}, 64'd1);
        if2.req_op[3:2] = 2'b11;
        tick();
        chk("xor_result", if2.rsp_result, 64'h0FF0_0FF0_0FF0_0FF0);
        chk("xor_id", {63'b0, if2.rsp_id}, 64'd1);
        if2.req_valid = 2'b00;
        tick();

        // Backpressure with both requesters valid
        if2.rsp_ready   = 1'b0;
        if2.req_valid   = 2'b11;
        if2.req_op[1:0] = 2'b01;
        if2.req_a[63:0] = 64'h1234_5678_9ABC_DEF0;
        if2.req_b[63:0] = 64'h0000_FFFF_0000_FFFF;
        tick();
        chk("bp_first_result", if2.rsp_result, 64'h0000_5678_0000_DEF0);
        held = if2.rsp_result;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_zero", {62'b0, if2.req_ready}, 64'd0);
            chk("bp_result_stable", if2.rsp_result, held);
            tick();
        end
        if2.rsp_ready = 1'b1;
        #1;
        chk("drain_grant_same_cycle", {63'b0, |if2.req_ready}, 64'd1);
        tick();
        chk("drain_refill_valid", {63'b0, if2.rsp_valid}, 64'd1);
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
        exp_id = 1;
`else
        exp_id = 0;
`endif
        chk("drain_refill_id", {63'b0, if2.rsp_id}, 64'(exp_id));
        if2.req_valid = 2'b00;
        tick();

        // Both requesters continuously valid from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if2.req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            chk("contend_id", {63'b0, if2.rsp_id}, 64'(exp_id));
        end
        if2.req_valid = 2'b10;
        tick();
        chk("only_req1_id", {63'b0, if2.rsp_id}, 64'd1);
        if2.req_valid = 2'b00;
        tick();

        // NREQ=3 pointer wrap
        if3.rsp_ready = 1'b1;
        if3.req_valid = 3'b100;
        if3.req_op    = 6'b11_10_01;
        if3.req_a     = {64'hAAAA_0000_5555_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h3333_3333_3333_3333};
        if3.req_b     = {64'hFFFF_FFFF_0000_0000, 64'h00FF_00FF_00FF_00FF, 64'h5555_5555_5555_5555};
        tick();
        chk("wrap_id2", {62'b0, if3.rsp_id}, 64'd2);
        chk("wrap_xor2", if3.rsp_result, 64'h5555_FFFF_5555_FFFF);
        if3.req_valid = 3'b011;
        tick();
        chk("wrap_id0", {62'b0, if3.rsp_id}, 64'd0);
        chk("wrap_and0", if3.rsp_result, 64'h1111_1111_1111_1111);
        tick();
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
        exp_id = 1;
`else
        exp_id = 0;
`endif
        chk("wrap_next_id", {62'b0, if3.rsp_id}, 64'(exp_id));
        if3.req_valid = 3'b000;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR) between NREQ requesters in the pipelined datapath. Each requester presents an opcode and operands with a valid/ready handshake. The block grants one request per cycle, computes the result, and holds it in a single-entry output register until the consumer accepts it. The arbitration policy is round-robin or fixed-priority, selected at compile time.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits
- NREQ, 2, number of requesters; legal range 2..4

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i has a request
- req_ready  output  NREQ  bit i: request i accepted this cycle; one-hot or zero
- req_op  input  2*NREQ  requester i at [2i+1:2i]; 00 NOT A, 01 A AND B, 10 A OR B, 11 A XOR B
- req_a  input  WIDTH*NREQ  operand A; requester i at [WIDTH*i +: WIDTH]
- req_b  input  WIDTH*NREQ  operand B, same packing; ignored for op 00
- rsp_valid  output  1  rsp_result/rsp_id hold a result
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  IDW  index of the requester that owns the result; IDW = max(1, $clog2(NREQ))
- rsp_result  output  WIDTH  registered result

## Operation
- Output register FSM has two states:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- A slot is free when the state is EMPTY, or when the state is FULL and rsp_ready=1 (drain and refill in the same cycle).
- Grant:
  - If the slot is free and any req_valid is set, exactly one requester is granted and its req_ready=1.
  - All other req_ready bits are 0.
  - req_ready is combinational from req_valid, state, rsp_ready and the priority pointer.
- On a grant: rsp_result ← op(req_a[g], req_b[g]), rsp_id ← g, state → FULL.
- FULL with rsp_ready=1 and no grant → EMPTY. rsp_result and rsp_id keep their old values.
- FULL with rsp_ready=0:
  - All req_ready bits are 0.
  - rsp_result and rsp_id stay stable.
- Opcode semantics: NOT is bitwise ~A over all WIDTH bits. There are no carries and no width extension.
- Round-robin pointer `last`:
  - Updates to g on every grant only.
  - Search order is last+1, last+2, … modulo NREQ, wrapping from NREQ-1 back to 0.
- A requester must hold req_valid, op and operands stable until its req_ready is 1. The block does not check this.

## Timing
- Latency: result visible in the cycle after the grant.
- Throughput: 1 result/cycle while rsp_ready=1.
- Reset (synchronous, evaluated at the clk edge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, last=NREQ-1, state EMPTY.
  - req_ready=0 in every cycle in which reset=1.
- Reset asserted while FULL: the held result is discarded and no handshake completes in that cycle.
- Simultaneous events:
  - Drain and grant in the same cycle: the new result replaces the old one with no bubble.
  - All requesters valid: exactly one grant per cycle.
- NREQ=2: IDW=1 and the pointer toggles.

## Configuration
- LOGIC_ARB_ROUND_ROBIN_EN defined:
  - Round-robin order as above.
  - A continuously valid requester waits at most NREQ-1 grants.
- LOGIC_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins.
  - `last` is not implemented.
  - A higher index may starve.

## Test plan
- Reset, then NOT: req 0 valid, op 00, A=64'h0 → the next cycle gives rsp_valid=1, rsp_id=0, rsp_result=64'hFFFF_FFFF_FFFF_FFFF. Assert reset while FULL → rsp_valid=0 on the next cycle.
- Opcode sweep on req 1: A=64'hF0F0_F0F0_F0F0_F0F0, B=64'hFF00_FF00_FF00_FF00 → AND gives 64'hF000_F000_F000_F000, OR gives 64'hFFF0_FFF0_FFF0_FFF0, XOR gives 64'h0FF0_0FF0_0FF0_0FF0, each with rsp_id=1.
- Backpressure: rsp_ready=0 for 5 cycles with both requests valid → req_ready=0 and rsp_result stable throughout. When rsp_ready rises, the drain and the next grant happen in the same cycle.
- Round robin (macro defined): NREQ=2, both requesters continuously valid, rsp_ready=1 → grants alternate 0,1,0,1, one per cycle, starting with 0 after reset.
- Fixed priority (macro undefined): same stimulus → 8 consecutive grants all to requester 0. Requester 1 is granted only once req_valid[0]=0.
- NREQ=3 wrap: requester 2 granted, then requesters 0 and 1 both valid → requester 0 granted next. Pointer wraps from 2 to 0.
